sram_req_ctrl: RTL and testbench

Request/response front end that turns a valid/ready bus transaction into the strobe sequence of single_port_ram (addr, bidirectional data, cs, we, oe). Sits directly upstream of the RAM and owns the shared data bus. It serialises one access at a time, captures read data, and returns a response for every accepted request.

---
 rtl/sram_req_ctrl_pkg.sv | 17 +
 rtl/sram_req_ctrl.sv | 158 +++++++++++++++
 tb/tb_sram_req_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_ctrl_pkg.sv
// Shared types and constants for the sram_req_ctrl request/response front end.
package sram_req_ctrl_pkg;

  localparam int CNT_W = 4;

  localparam logic CS_IDLE = 1'b1;
  localparam logic WE_IDLE = 1'b1;
  localparam logic OE_IDLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/sram_req_ctrl.sv
// Valid/ready front end driving a single-port SRAM strobe sequence, one access at a time.
// Optional address range check enabled by defining SRAM_REQ_CTRL_RANGE_CHK_EN.
module sram_req_ctrl
  import sram_req_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [1:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid is not required to stay up, and ready does not depend on valid.

`ifdef SRAM_REQ_CTRL_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_oe_q, mem_oe_d;
  logic                  addr_oob;

  // Folds to 0 when the range check is compiled out, so every address reaches the RAM.
  assign addr_oob = RANGE_CHK && ({1'b0, req_addr} >= (ADDR_WIDTH+1)'(DEPTH));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_cs_d    = mem_cs_q;
    mem_we_d    = mem_we_q;
    mem_oe_d    = mem_oe_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          wdata_d = req_wdata;
          if (addr_oob) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            mem_addr_d = req_addr;
            mem_cs_d   = 1'b0;
            rsp_err_d  = 1'b0;
            if (req_we) begin
              state_d  = ST_WRITE;
              mem_we_d = 1'b0;
              mem_oe_d = 1'b1;
            end else begin
              state_d = ST_READ;
              cnt_d   = CNT_W'(RD_LAT - 1);
            end
          end
        end
      end
      ST_WRITE: begin
        state_d     = ST_RESP;
        mem_cs_d    = CS_IDLE;
        mem_we_d    = WE_IDLE;
        mem_oe_d    = OE_IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
      end
      ST_READ: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          mem_cs_d    = CS_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_data;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_cs_q    <= CS_IDLE;
      mem_we_q    <= WE_IDLE;
      mem_oe_q    <= OE_IDLE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_oe_q    <= mem_oe_d;
    end
  end

  assign mem_data  = mem_oe_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_oe    = mem_oe_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: behavioural SRAM on the bus, memory model plus expected-response queue.
module tb_sram_req_ctrl;

  localparam int AW     = 16;
  localparam int DW     = 32;
  localparam int DEPTH  = 32;
  localparam int RD_LAT = 3;

`ifdef SRAM_REQ_CTRL_RANGE_CHK_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic          mem_cs, mem_we, mem_oe;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];

  int  cs_cnt = 0;
  int  we_cnt = 0;
  logic rd_prev = 1'b0;

  sram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_oe(mem_oe), .dbg_state(dbg_state)
  );

  // clock / behavioural RAM
  always #5 clk = ~clk;

  assign mem_data = (!mem_cs && mem_we && !mem_oe) ? ram[mem_addr[4:0]] : {DW{1'bz}};

  always @(posedge clk) begin
    if (!mem_cs && !mem_we) ram[mem_addr[4:0]] <= mem_data;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // strobe counters and bus-turnaround watch
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_prev = 1'b0;
    end else begin
      logic rd_now;
      rd_now = !mem_cs && mem_we;
      if (!mem_cs) cs_cnt++;
      if (!mem_we) we_cnt++;
      if (mem_oe || rd_now || rd_prev)
        chk("turnaround", {31'b0, mem_oe && (rd_now || rd_prev)}, 32'd0);
      if (rd_now) chk("rd_bus_x", {31'b0, $isunknown(mem_data)}, 32'd0);
      rd_prev = rd_now;
    end
  end

  // One full access: request, latency and strobe checks, response stall, handshake.
  task automatic do_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int stall, input bit hold_valid);
    int guard;
    int lat;
    bit oob;
    int exp_lat;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] got;
    oob = CHK_ON && (addr >= AW'(DEPTH));
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    if (oob) begin
      exp_q.push_back('0);
      exp_lat = 1;
    end else if (we) begin
      exp_q.push_back('0);
      model_mem[addr % DEPTH] = wdata;
      exp_lat = 2;
    end else begin
      exp_q.push_back(model_mem[addr % DEPTH]);
      exp_lat = 1 + RD_LAT;
    end
    @(posedge clk);
    cs_cnt = 0;
    we_cnt = 0;
    @(negedge clk);
    if (hold_valid) begin
      req_we    = 1'($urandom);
      req_addr  = AW'($urandom_range(0, DEPTH + 3));
      req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    lat = 1;
    chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_latency", DW'(lat), DW'(exp_lat));
    exp_rd = exp_q.pop_front();
    got = rsp_rdata;
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, oob});
    chk("cs_cycles", DW'(cs_cnt), oob ? 32'd0 : (we ? 32'd1 : DW'(RD_LAT)));
    chk("we_cycles", DW'(we_cnt), (!oob && we) ? 32'd1 : 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_rdata", rsp_rdata, got);
      chk("stall_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("rsp_drop", {31'b0, rsp_valid}, 32'd0);
    chk("back_idle", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = '0;
      model_mem[i] = '0;
    end
    rsp_ready = 1'b1;
    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_cs", {31'b0, mem_cs}, 32'd1);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd1);
    chk("rst_mem_oe", {31'b0, mem_oe}, 32'd0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, 32'd0);
    chk("rst_bus_z", {31'b0, mem_data === {DW{1'bz}}}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    // rsp_ready high before any response must do nothing
    repeat (2) @(negedge clk);
    chk("early_rsp_ready", {31'b0, rsp_valid}, 32'd0);
    rsp_ready = 1'b0;

    do_access(1'b1, 16'h0003, 32'hDEADBEEF, 0, 1'b0);
    do_access(1'b0, 16'h0003, 32'h0, 0, 1'b0);
    do_access(1'b0, 16'h0003, 32'h0, 5, 1'b0);
    do_access(1'b1, 16'h001F, 32'h12345678, 0, 1'b1);
    do_access(1'b0, 16'h001F, 32'h0, 0, 1'b1);
    do_access(1'b0, 16'h0020, 32'h0, 1, 1'b0);
    do_access(1'b1, 16'h0020, 32'hCAFEF00D, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, DEPTH + 3))
                                      : AW'($urandom_range(0, DEPTH - 1));
      do_access(1'($urandom), a, $urandom, $urandom_range(0, 3), 1'($urandom));
    end

    // reset pulse in the middle of a read
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0005;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_cs", {31'b0, mem_cs}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("arst_mem_cs", {31'b0, mem_cs}, 32'd1);
    chk("arst_mem_we", {31'b0, mem_we}, 32'd1);
    chk("arst_mem_oe", {31'b0, mem_oe}, 32'd0);
    chk("arst_mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("arst_rdata", rsp_rdata, 32'd0);
    chk("arst_bus_z", {31'b0, mem_data === {DW{1'bz}}}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    rsp_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    chk("no_rsp_after_rst", DW'(seen), 32'd0);
    do_access(1'b0, 16'h0003, 32'h0, 0, 1'b0);
    do_access(1'b1, 16'h0007, 32'hA5A5_5A5A, 2, 1'b0);
    do_access(1'b0, 16'h0007, 32'h0, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
